// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//
// Execution datapath of the K&S 16-bit processor: program counter, instruction
// register, 4x16 register file, 2-bit-op ALU and registered status flags. The
// control FSM drives the strobes below every clock; this block returns the
// decoded instruction and the flags to it.
//
// Ports
//   clk                 system clock, all state updates on the rising edge
//   rst_n               synchronous active-low reset
//   branch              with pc_enable: PC loads IR[4:0] instead of PC+1
//   pc_enable           PC update strobe
//   ir_enable           IR <= data_in
//   addr_sel            0: ram_addr = PC, 1: ram_addr = IR[4:0]
//   c_sel               register write source: 0 ALU result, 1 data_in
//   write_reg_enable    register file write strobe
//   operation[1:0]      ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   data_in[15:0]       RAM read data
//   ram_addr[4:0]       RAM address (combinational)
//   data_out[15:0]      RAM write data = register read port A (combinational)
//   decoded_instruction instruction code decoded from IR (combinational)
//   zero/neg/unsigned_overflow/signed_overflow  registered ALU flags
// -----------------------------------------------------------------------------
module datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic        pc_enable,
  input  logic        ir_enable,
  input  logic        addr_sel,
  input  logic        c_sel,
  input  logic        write_reg_enable,
  input  logic [1:0]  operation,
  input  logic [15:0] data_in,
  output logic [4:0]  ram_addr,
  output logic [15:0] data_out,
  output logic [4:0]  decoded_instruction,
  output logic        zero,
  output logic        neg,
  output logic        unsigned_overflow,
  output logic        signed_overflow
);

  // Instruction codes returned to control
  localparam logic [4:0] I_NOP    = 5'd0;
  localparam logic [4:0] I_LOAD   = 5'd1;
  localparam logic [4:0] I_STORE  = 5'd2;
  localparam logic [4:0] I_MOVE   = 5'd3;
  localparam logic [4:0] I_ADD    = 5'd4;
  localparam logic [4:0] I_SUB    = 5'd5;
  localparam logic [4:0] I_AND    = 5'd6;
  localparam logic [4:0] I_OR     = 5'd7;
  localparam logic [4:0] I_BRANCH = 5'd8;
  localparam logic [4:0] I_BZERO  = 5'd9;
  localparam logic [4:0] I_BNZERO = 5'd10;
  localparam logic [4:0] I_BNEG   = 5'd11;
  localparam logic [4:0] I_BNNEG  = 5'd12;
  localparam logic [4:0] I_BOV    = 5'd13;
  localparam logic [4:0] I_BNOV   = 5'd14;
  localparam logic [4:0] I_BUOV   = 5'd15;
  localparam logic [4:0] I_BNUOV  = 5'd16;
  localparam logic [4:0] I_HALT   = 5'd17;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [4:0]  r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_regs [4];
  logic        r_zero;
  logic        r_neg;
  logic        r_uov;
  logic        r_sov;

  logic [4:0]  w_dec;
  logic [1:0]  w_ra_idx;
  logic [1:0]  w_rb_idx;
  logic [1:0]  w_wr_idx;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [15:0] w_result;
  logic        w_uov;
  logic        w_sov;
  logic [15:0] w_wr_data;

  // ---------------------------------------------------------------------------
  // Instruction decode. Branches require IR[7:5]==0; anything unrecognised
  // falls back to NOP so control never sees an undefined code.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dec = I_NOP;
    if (r_ir == 16'hFFFF) begin
      w_dec = I_HALT;
    end else begin
      case (r_ir[15:8])
        8'h81: w_dec = I_LOAD;
        8'h82: w_dec = I_STORE;
        8'h91: w_dec = I_MOVE;
        8'hA1: w_dec = I_ADD;
        8'hA2: w_dec = I_SUB;
        8'hA3: w_dec = I_AND;
        8'hA4: w_dec = I_OR;
        8'h01: if (r_ir[7:5] == 3'b000) w_dec = I_BRANCH;
        8'h02: if (r_ir[7:5] == 3'b000) w_dec = I_BZERO;
        8'h03: if (r_ir[7:5] == 3'b000) w_dec = I_BNZERO;
        8'h04: if (r_ir[7:5] == 3'b000) w_dec = I_BNEG;
        8'h05: if (r_ir[7:5] == 3'b000) w_dec = I_BNNEG;
        8'h06: if (r_ir[7:5] == 3'b000) w_dec = I_BOV;
        8'h07: if (r_ir[7:5] == 3'b000) w_dec = I_BNOV;
        8'h08: if (r_ir[7:5] == 3'b000) w_dec = I_BUOV;
        8'h09: if (r_ir[7:5] == 3'b000) w_dec = I_BNUOV;
        default: w_dec = I_NOP;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file index selection. MOVE reads Rs on both ports so that an OR
  // operation passes it through unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ra_idx = r_ir[3:2];
    w_wr_idx = r_ir[5:4];
    w_rb_idx = r_ir[1:0];
    if (w_dec == I_STORE) w_ra_idx = r_ir[6:5];
    if (w_dec == I_MOVE)  w_ra_idx = r_ir[1:0];
    if (w_dec == I_LOAD)  w_wr_idx = r_ir[6:5];
    if (w_dec == I_MOVE)  w_wr_idx = r_ir[3:2];
  end

  assign w_a = r_regs[w_ra_idx];
  assign w_b = r_regs[w_rb_idx];

  // ---------------------------------------------------------------------------
  // ALU. The 17-bit sum carries the unsigned carry; the 17-bit difference has
  // its MSB set exactly when a < b unsigned (borrow).
  // ---------------------------------------------------------------------------
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_result = w_a | w_b;
    w_uov    = 1'b0;
    w_sov    = 1'b0;
    case (operation)
      OP_ADD: begin
        w_result = w_sum[15:0];
        w_uov    = w_sum[16];
        // Operands share a sign and the result sign differs
        w_sov    = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
      end
      OP_SUB: begin
        w_result = w_diff[15:0];
        w_uov    = w_diff[16];
        // Operands differ in sign and the result sign differs from a
        w_sov    = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);
      end
      OP_AND: w_result = w_a & w_b;
      default: w_result = w_a | w_b;
    endcase
  end

  assign w_wr_data = c_sel ? data_in : w_result;

  // ---------------------------------------------------------------------------
  // State. All updates use pre-edge values, so simultaneous strobes are
  // independent (e.g. a register write uses the IR from before an IR load).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      if (pc_enable) r_pc <= branch ? r_ir[4:0] : r_pc + 5'd1;
      if (ir_enable) r_ir <= data_in;
      if (write_reg_enable) begin
        r_regs[w_wr_idx] <= w_wr_data;
        // Memory loads leave the flags untouched
        if (!c_sel) begin
          r_zero <= (w_result == 16'h0000);
          r_neg  <= w_result[15];
          r_uov  <= w_uov;
          r_sov  <= w_sov;
        end
      end
    end
  end

  assign ram_addr            = addr_sel ? r_ir[4:0] : r_pc;
  assign data_out            = w_a;
  assign decoded_instruction = w_dec;
  assign zero                = r_zero;
  assign neg                 = r_neg;
  assign unsigned_overflow   = r_uov;
  assign signed_overflow     = r_sov;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//
// Directed testbench for datapath. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, well away from the next edge.
// Flags are compared packed as {zero, neg, unsigned_overflow, signed_overflow}.
// -----------------------------------------------------------------------------
module tb_datapath;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic        pc_enable;
  logic        ir_enable;
  logic        addr_sel;
  logic        c_sel;
  logic        write_reg_enable;
  logic [1:0]  operation;
  logic [15:0] data_in;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;
  logic [4:0]  decoded_instruction;
  logic        zero;
  logic        neg;
  logic        unsigned_overflow;
  logic        signed_overflow;

  int n_vec = 0;
  int n_bad = 0;

  datapath dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .write_reg_enable    (write_reg_enable),
    .operation           (operation),
    .data_in             (data_in),
    .ram_addr            (ram_addr),
    .data_out            (data_out),
    .decoded_instruction (decoded_instruction),
    .zero                (zero),
    .neg                 (neg),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
    $display("vector %0d %s: observed 0x%04h expected 0x%04h", n_vec, tag, obs, exp);
  endtask

  function automatic logic [15:0] flags();
    return {12'h000, zero, neg, unsigned_overflow, signed_overflow};
  endfunction

  task automatic load_ir(input logic [15:0] v);
    data_in   = v;
    ir_enable = 1'b1;
    tick();
    ir_enable = 1'b0;
  endtask

  // IR <- LOAD instruction, then write val from data_in into its target
  task automatic load_reg(input logic [15:0] irv, input logic [15:0] val);
    load_ir(irv);
    data_in          = val;
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    c_sel            = 1'b0;
  endtask

  task automatic alu_op(input logic [15:0] irv, input logic [1:0] op);
    load_ir(irv);
    operation        = op;
    c_sel            = 1'b0;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
    addr_sel = 1'b0; c_sel = 1'b0; write_reg_enable = 1'b0;
    operation = 2'b00; data_in = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("reset_ram_addr", {11'd0, ram_addr}, 16'd0);
    chk("reset_data_out", data_out, 16'h0000);
    chk("reset_decoded",  {11'd0, decoded_instruction}, 16'd0);
    chk("reset_flags",    flags(), 16'h0000);

    // Fetch
    load_ir(16'h8105);
    chk("fetch_decoded", {11'd0, decoded_instruction}, 16'd1);
    chk("fetch_addr_pc", {11'd0, ram_addr}, 16'd0);
    addr_sel = 1'b1;
    #1;
    chk("fetch_addr_ir", {11'd0, ram_addr}, 16'd5);
    addr_sel = 1'b0;

    // LOAD writeback: R1 <- 0x7FFF; port A (IR[3:2]=1) shows R1
    load_reg(16'h8125, 16'h7FFF);
    chk("load_r1",    data_out, 16'h7FFF);
    chk("load_flags", flags(), 16'h0000);
    load_reg(16'h8145, 16'h0001);            // R2 = 1
    chk("load_r2_flags", flags(), 16'h0000);

    // ADD overflow: R0 = R1 + R2
    alu_op(16'hA106, 2'b00);
    chk("add_flags", flags(), 16'h0005);      // neg=1, sov=1
    load_ir(16'h8200);                        // STORE R0 -> port A = R0
    chk("add_result", data_out, 16'h8000);

    // SUB to zero: R1 = R2 = 3
    load_reg(16'h8125, 16'h0003);
    load_reg(16'h8145, 16'h0003);
    alu_op(16'hA206, 2'b01);
    chk("sub_zero_flags", flags(), 16'h0008);
    load_ir(16'h8200);
    chk("sub_zero_result", data_out, 16'h0000);

    // SUB borrow: 0 - 1
    load_reg(16'h8125, 16'h0000);
    load_reg(16'h8145, 16'h0001);
    alu_op(16'hA206, 2'b01);
    chk("sub_borrow_flags", flags(), 16'h0006); // neg=1, uov=1
    load_ir(16'h8200);
    chk("sub_borrow_result", data_out, 16'hFFFF);

    // ADD carry out: 0xFFFF + 0x0001 = 0 with unsigned overflow
    load_reg(16'h8125, 16'hFFFF);
    alu_op(16'hA106, 2'b00);
    chk("add_carry_flags", flags(), 16'h000A);  // zero=1, uov=1

    // AND clears overflow flags: 0xFFFF & 0x0001
    alu_op(16'hA306, 2'b10);
    chk("and_flags", flags(), 16'h0000);
    load_ir(16'h8200);
    chk("and_result", data_out, 16'h0001);

    // LOAD leaves flags alone even after they were set
    alu_op(16'hA206, 2'b01);                  // 0xFFFF - 1 = 0xFFFE, neg
    chk("sub_neg_flags", flags(), 16'h0004);
    load_reg(16'h8125, 16'h0000);
    chk("load_keeps_flags", flags(), 16'h0004);

    // PC increment and wrap
    pc_enable = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    pc_enable = 1'b0;
    chk("pc_31", {11'd0, ram_addr}, 16'd31);
    pc_enable = 1'b1;
    tick();
    pc_enable = 1'b0;
    chk("pc_wrap", {11'd0, ram_addr}, 16'd0);

    // Branch
    load_ir(16'h0213);
    chk("bzero_decoded", {11'd0, decoded_instruction}, 16'd9);
    pc_enable = 1'b1; branch = 1'b1;
    tick();
    pc_enable = 1'b0;
    chk("branch_pc", {11'd0, ram_addr}, 16'd19);
    tick();                                    // branch=1, pc_enable=0
    branch = 1'b0;
    chk("branch_hold", {11'd0, ram_addr}, 16'd19);

    // Simultaneous IR load and PC advance use pre-edge values
    data_in = 16'h0905; ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b1;
    tick();
    ir_enable = 1'b0; pc_enable = 1'b0; branch = 1'b0;
    chk("simul_pc", {11'd0, ram_addr}, 16'd19);  // branched to old IR[4:0]
    chk("simul_decoded", {11'd0, decoded_instruction}, 16'd16);

    // STORE / MOVE
    load_reg(16'h8165, 16'hBEEF);              // R3 = 0xBEEF
    load_ir(16'h8265);
    chk("store_data", data_out, 16'hBEEF);
    addr_sel = 1'b1;
    #1;
    chk("store_addr", {11'd0, ram_addr}, 16'd5);
    addr_sel = 1'b0;
    alu_op(16'h9107, 2'b11);                   // MOVE R1 <- R3 as OR
    chk("move_flags", flags(), 16'h0004);
    load_ir(16'h8225);                         // STORE R1
    chk("move_result", data_out, 16'hBEEF);

    // Decode edge cases
    load_ir(16'hFFFF);
    chk("halt_decoded", {11'd0, decoded_instruction}, 16'd17);
    load_ir(16'h1234);
    chk("unknown_decoded", {11'd0, decoded_instruction}, 16'd0);
    load_ir(16'h0120);
    chk("branch_bad_bits", {11'd0, decoded_instruction}, 16'd0);
    load_ir(16'hA4E1);
    chk("or_decoded", {11'd0, decoded_instruction}, 16'd7);

    // Reset mid-instruction overrides every strobe
    data_in = 16'h8165; ir_enable = 1'b1; pc_enable = 1'b1;
    write_reg_enable = 1'b1; c_sel = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ir_enable = 1'b0; pc_enable = 1'b0;
    write_reg_enable = 1'b0; c_sel = 1'b0;
    chk("rst_mid_pc",      {11'd0, ram_addr}, 16'd0);
    chk("rst_mid_decoded", {11'd0, decoded_instruction}, 16'd0);
    chk("rst_mid_flags",   flags(), 16'h0000);
    load_ir(16'h8260);                          // STORE R3 -> cleared
    chk("rst_mid_r3", data_out, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Datapath of the K&S 16-bit processor: program counter, instruction register, 4×16 register file, 2-bit-op ALU and registered status flags. It sits directly downstream of `control`, executing its one-hot-ish strobes each clock. It sits upstream of `control` too, returning the decoded opcode and the flags. It drives the RAM address and write data and takes RAM read data.

## Interface
- (no parameters) — data width fixed at 16, address width fixed at 5 (32-word RAM)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- branch  in  1  with pc_enable: PC loads IR[4:0] instead of PC+1
- pc_enable  in  1  PC update strobe
- ir_enable  in  1  IR <= data_in
- addr_sel  in  1  0: ram_addr = PC; 1: ram_addr = IR[4:0]
- c_sel  in  1  register write source: 0 ALU result, 1 data_in
- write_reg_enable  in  1  register file write strobe
- operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- data_in  in  16  RAM read data
- ram_addr  out  5  RAM address (combinational)
- data_out  out  16  RAM write data = register read port A (combinational)
- decoded_instruction  out  5  instruction code decoded combinationally from IR
- zero, neg, unsigned_overflow, signed_overflow  out  1 each  registered ALU flags

## Operation
- Encoding (IR[15:8] opcode): NOP 0x00 with IR=0x0000; BRANCH 0x01, BZERO 0x02, BNZERO 0x03, BNEG 0x04, BNNEG 0x05, BOV 0x06, BNOV 0x07, BUOV 0x08, BNUOV 0x09 (target IR[4:0]); LOAD 0x81, STORE 0x82 (reg IR[6:5], addr IR[4:0]); MOVE 0x91 (Rd IR[3:2], Rs IR[1:0]); ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4 (Rc IR[5:4], Ra IR[3:2], Rb IR[1:0]); HALT IR=0xFFFF.
- decoded_instruction codes: NOP 0, LOAD 1, STORE 2, MOVE 3, ADD 4, SUB 5, AND 6, OR 7, BRANCH 8, BZERO 9, BNZERO 10, BNEG 11, BNNEG 12, BOV 13, BNOV 14, BUOV 15, BNUOV 16, HALT 17. Any unlisted pattern, including a branch with nonzero IR[7:5], decodes to NOP (0).
- Read port A index: STORE IR[6:5]; MOVE IR[1:0]; otherwise IR[3:2]. Port B index: IR[1:0].
- Write index: LOAD IR[6:5]; MOVE IR[3:2]; otherwise IR[5:4].
- MOVE is executed by control as OR with A=B=Rs.
- ALU: ADD a+b, unsigned_overflow = carry out of bit 15. SUB a−b, unsigned_overflow = borrow (a<b unsigned).
- signed_overflow (ADD/SUB): two's-complement rule. For AND/OR both overflow flags are 0.
- zero = (result==0); neg = result[15].
- Flags register only when write_reg_enable=1 and c_sel=0; otherwise they hold. LOAD (c_sel=1) does not touch flags.
- PC update when pc_enable=1: branch=1 loads IR[4:0]; otherwise PC+1 mod 32 (31→0).
- branch is ignored when pc_enable=0.
- Simultaneous strobes are independent. ir_enable with pc_enable in one cycle loads IR from data_in and advances PC, both from pre-edge values. A register write uses the pre-edge IR.

## Timing
- Reset (rst_n=0 at edge): PC=0, IR=0x0000, R0–R3=0, all four flags 0. Consequently ram_addr=0, data_out=0, decoded_instruction=0 (NOP).
- Reset asserted mid-instruction overrides every strobe in that cycle.
- ram_addr, data_out and decoded_instruction are combinational from current PC/IR/registers: valid in the same cycle as addr_sel changes, and one cycle after the ir_enable edge.
- Register write is visible on the read ports the cycle after the write edge (no write-through bypass).
- Flags are visible the cycle after the ALU write edge.

## Test plan
- Reset, then fetch: data_in=0x8105, ir_enable=1 for one cycle → decoded_instruction=1, ram_addr=0 (addr_sel=0). Then addr_sel=1 → ram_addr=5.
- LOAD writeback: IR=0x8125, data_in=0x7FFF, c_sel=1, write_reg_enable=1 → R1=0x7FFF; flags unchanged from 0.
- ADD overflow: R1=0x7FFF, R2=0x0001, IR=0xA106 (R0=R1+R2), operation=00, write → R0=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB borrow and zero: R1=R2=0x0003, SUB → result 0, zero=1, unsigned_overflow=0. Then R1=0x0000 − R2=0x0001 → 0xFFFF, unsigned_overflow=1, neg=1.
- PC: 32 pc_enable pulses with branch=0 → PC returns 0 (31→0 wrap). IR=0x0213, pc_enable=1, branch=1 → PC=19. branch=1 with pc_enable=0 → PC holds.
- STORE/MOVE data path: IR=0x8265 with R3=0xBEEF → data_out=0xBEEF, ram_addr=5 with addr_sel=1. IR=0x9107 (R1←R3) as OR → R1=0xBEEF, neg=1. IR=0xFFFF → decoded 17; IR=0x1234 → decoded 0.
